// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three SRAM requesters, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view. The master modport is the requesters' and memory's view.
interface mem_arbiter_if;
    logic        i_jtagReq;
    logic        i_jtagWr;
    logic [15:0] i_jtagAddr;
    logic [15:0] i_jtagData;
    logic        o_jtagAck;

    logic        i_instReq;
    logic        i_instWr;
    logic [15:0] i_instAddr;
    logic [15:0] i_instData;
    logic        o_instAck;

    logic        i_dataReq;
    logic        i_dataWr;
    logic [15:0] i_dataAddr;
    logic [15:0] i_dataData;
    logic        o_dataAck;

    logic [15:0] o_rdData;
    logic [1:0]  o_grant;
    logic        o_busy;
    logic [15:0] o_memAddr;
    logic        o_memEn;
    logic        o_memWr;
    logic [15:0] o_memDataOut;
    logic        o_memDataOe;
    logic [15:0] i_memDataIn;

    modport slave (
        input  i_jtagReq, i_jtagWr, i_jtagAddr, i_jtagData,
        input  i_instReq, i_instWr, i_instAddr, i_instData,
        input  i_dataReq, i_dataWr, i_dataAddr, i_dataData,
        input  i_memDataIn,
        output o_jtagAck, o_instAck, o_dataAck,
        output o_rdData, o_grant, o_busy,
        output o_memAddr, o_memEn, o_memWr, o_memDataOut, o_memDataOe
    );

    modport master (
        output i_jtagReq, i_jtagWr, i_jtagAddr, i_jtagData,
        output i_instReq, i_instWr, i_instAddr, i_instData,
        output i_dataReq, i_dataWr, i_dataAddr, i_dataData,
        output i_memDataIn,
        input  o_jtagAck, o_instAck, o_dataAck,
        input  o_rdData, o_grant, o_busy,
        input  o_memAddr, o_memEn, o_memWr, o_memDataOut, o_memDataOe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single SRAM port between the jtag, inst and data requesters.
// It also sequences the enable, write strobe and data-drive timing for the SRAM.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_waitCyclesCheck
        $error("mem_arbiter: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_JTAG = 2'd1;
    localparam logic [1:0] OWN_INST = 2'd2;
    localparam logic [1:0] OWN_DATA = 2'd3;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_e      stateQ;
    logic [1:0]  grantQ;
    logic [3:0]  cntQ;
    logic        wrQ;
    logic [15:0] addrQ;
    logic [15:0] dataQ;
    logic [15:0] rdDataQ;
    logic        lastIsDataQ;

    logic [1:0]  winnerD;
    logic        winWrD;
    logic [15:0] winAddrD;
    logic [15:0] winDataD;

    // jtag always wins; an inst/data tie goes to whichever was not served last.
    always_comb begin
        winnerD  = OWN_NONE;
        winWrD   = 1'b0;
        winAddrD = 16'h0000;
        winDataD = 16'h0000;
        if (bus.i_jtagReq) begin
            winnerD = OWN_JTAG;
        end else if (bus.i_instReq && bus.i_dataReq) begin
            winnerD = lastIsDataQ ? OWN_INST : OWN_DATA;
        end else if (bus.i_instReq) begin
            winnerD = OWN_INST;
        end else if (bus.i_dataReq) begin
            winnerD = OWN_DATA;
        end
        case (winnerD)
            OWN_JTAG: begin
                winWrD   = bus.i_jtagWr;
                winAddrD = bus.i_jtagAddr;
                winDataD = bus.i_jtagData;
            end
            OWN_INST: begin
                winWrD   = bus.i_instWr;
                winAddrD = bus.i_instAddr;
                winDataD = bus.i_instData;
            end
            OWN_DATA: begin
                winWrD   = bus.i_dataWr;
                winAddrD = bus.i_dataAddr;
                winDataD = bus.i_dataData;
            end
            default: begin
                winWrD   = 1'b0;
                winAddrD = 16'h0000;
                winDataD = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ      <= IDLE;
            grantQ      <= OWN_NONE;
            cntQ        <= 4'd0;
            wrQ         <= 1'b0;
            addrQ       <= 16'h0000;
            dataQ       <= 16'h0000;
            rdDataQ     <= 16'h0000;
            lastIsDataQ <= 1'b1;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (winnerD != OWN_NONE) begin
                        grantQ <= winnerD;
                        wrQ    <= winWrD;
                        addrQ  <= winAddrD;
                        dataQ  <= winDataD;
                        cntQ   <= CNT_LOAD;
                        stateQ <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cntQ == 4'd0) begin
                        if (!wrQ) begin
                            rdDataQ <= bus.i_memDataIn;
                        end
                        stateQ <= DONE;
                    end else begin
                        cntQ <= cntQ - 4'd1;
                    end
                end
                DONE: begin
                    // A jtag transaction leaves the inst/data round-robin untouched.
                    if (grantQ == OWN_INST) begin
                        lastIsDataQ <= 1'b0;
                    end else if (grantQ == OWN_DATA) begin
                        lastIsDataQ <= 1'b1;
                    end
                    grantQ <= OWN_NONE;
                    stateQ <= IDLE;
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    // Pin timing is decoded purely from state, so reset drops the strobes at once.
    assign bus.o_memEn      = (stateQ == ACCESS);
    assign bus.o_memWr      = (stateQ == ACCESS) && wrQ;
    assign bus.o_memDataOe  = (stateQ == ACCESS) && wrQ;
    assign bus.o_memAddr    = addrQ;
    assign bus.o_memDataOut = dataQ;
    assign bus.o_rdData     = rdDataQ;
    assign bus.o_grant      = grantQ;
    assign bus.o_busy       = (stateQ != IDLE);
    assign bus.o_jtagAck    = (stateQ == DONE) && (grantQ == OWN_JTAG);
    assign bus.o_instAck    = (stateQ == DONE) && (grantQ == OWN_INST);
    assign bus.o_dataAck    = (stateQ == DONE) && (grantQ == OWN_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of priority, round-robin and memory contents.
module tb_mem_arbiter;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();
    mem_arbiter_if bus15 ();

    mem_arbiter #(.WAIT_CYCLES(W))  dut   (.i_clk(clk), .i_rst(rst), .bus(bus));
    mem_arbiter #(.WAIT_CYCLES(1))  dut1  (.i_clk(clk), .i_rst(rst), .bus(bus1));
    mem_arbiter #(.WAIT_CYCLES(15)) dut15 (.i_clk(clk), .i_rst(rst), .bus(bus15));

    always #5 clk = ~clk;

    // SRAM model: an unwritten word reads back as its address XOR 0x5A5A.
    logic [15:0] sram    [0:65535];
    bit          written [0:65535];
    always @(posedge clk) begin
        if (bus.o_memEn && bus.o_memWr) begin
            sram[bus.o_memAddr]    <= bus.o_memDataOut;
            written[bus.o_memAddr] <= 1'b1;
        end
    end
    assign bus.i_memDataIn   = written[bus.o_memAddr] ? sram[bus.o_memAddr] : (bus.o_memAddr ^ 16'h5A5A);
    assign bus1.i_memDataIn  = 16'hC0DE;
    assign bus15.i_memDataIn = 16'hC0DE;

    logic [15:0] refMem [0:65535];
    logic [15:0] refRdData;
    bit          refLastIsData;

    task automatic setReq(input int r, input logic req, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data);
        case (r)
            0: begin bus.i_jtagReq = req; bus.i_jtagWr = wr; bus.i_jtagAddr = addr; bus.i_jtagData = data; end
            1: begin bus.i_instReq = req; bus.i_instWr = wr; bus.i_instAddr = addr; bus.i_instData = data; end
            default: begin bus.i_dataReq = req; bus.i_dataWr = wr; bus.i_dataAddr = addr; bus.i_dataData = data; end
        endcase
    endtask

    task automatic dropReq(input int r);
        case (r)
            0: bus.i_jtagReq = 1'b0;
            1: bus.i_instReq = 1'b0;
            default: bus.i_dataReq = 1'b0;
        endcase
    endtask

    function automatic logic [2:0] ackVec();
        return {bus.o_dataAck, bus.o_instAck, bus.o_jtagAck};
    endfunction

    task automatic clearAll();
        for (int r = 0; r < 3; r++) setReq(r, 1'b0, 1'b0, 16'h0, 16'h0);
        bus1.i_jtagReq = 0; bus1.i_jtagWr = 0; bus1.i_jtagAddr = 0; bus1.i_jtagData = 0;
        bus1.i_instReq = 0; bus1.i_instWr = 0; bus1.i_instAddr = 0; bus1.i_instData = 0;
        bus1.i_dataReq = 0; bus1.i_dataWr = 0; bus1.i_dataAddr = 0; bus1.i_dataData = 0;
        bus15.i_jtagReq = 0; bus15.i_jtagWr = 0; bus15.i_jtagAddr = 0; bus15.i_jtagData = 0;
        bus15.i_instReq = 0; bus15.i_instWr = 0; bus15.i_instAddr = 0; bus15.i_instData = 0;
        bus15.i_dataReq = 0; bus15.i_dataWr = 0; bus15.i_dataAddr = 0; bus15.i_dataData = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        clearAll();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        refLastIsData = 1'b1;
        refRdData     = 16'h0000;
    endtask

    // Reset values, then an asynchronous reset in the middle of a write.
    task automatic test_reset();
        logic [2:0] av;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_grant, bus.o_busy, bus.o_memEn, bus.o_memWr, bus.o_memDataOe} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000",
                     {bus.o_grant, bus.o_busy, bus.o_memEn, bus.o_memWr, bus.o_memDataOe});
        end
        checks++;
        if ({bus.o_memAddr, bus.o_memDataOut, bus.o_rdData} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 0", {bus.o_memAddr, bus.o_memDataOut, bus.o_rdData});
        end
        checks++;
        av = ackVec();
        if (av !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b want 000", av);
        end
        rst = 1'b0;
        refLastIsData = 1'b1;
        refRdData     = 16'h0000;
        setReq(2, 1'b1, 1'b1, 16'h0042, 16'h1111);
        @(negedge clk);
        checks++;
        if ({bus.o_memEn, bus.o_memWr, bus.o_memDataOe} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_pre_write: got %b want 111", {bus.o_memEn, bus.o_memWr, bus.o_memDataOe});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_memEn, bus.o_memWr, bus.o_memDataOe, bus.o_busy, bus.o_grant} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_midop: got %b want 000000",
                     {bus.o_memEn, bus.o_memWr, bus.o_memDataOe, bus.o_busy, bus.o_grant});
        end
        dropReq(2);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            av = ackVec();
            if (av !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_no_ack: got %b want 000", av);
            end
        end
        rst = 1'b0;
        refLastIsData = 1'b1;
        setReq(1, 1'b1, 1'b0, 16'h0042, 16'h0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (bus.o_grant !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL reset_regrant: got %0d want 2", bus.o_grant);
                end
            end
            if (n == 3) begin
                checks++;
                av = ackVec();
                if (av !== 3'b010 || bus.o_rdData !== refMem[16'h0042]) begin
                    errors++;
                    $display("[TB] FAIL reset_after_read: got ack %b data %h want ack 010 data %h",
                             av, bus.o_rdData, refMem[16'h0042]);
                end
                dropReq(1);
                refRdData = refMem[16'h0042];
                refLastIsData = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [2:0] av;
        setReq(0, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 3) begin
                checks++;
                av = ackVec();
                if (av !== 3'b001) begin
                    errors++;
                    $display("[TB] FAIL preload_ack: got %b want 001", av);
                end
                dropReq(0);
            end
        end
        refMem[16'h1234] = 16'hBEEF;
        @(negedge clk);
        setReq(1, 1'b1, 1'b0, 16'h1234, 16'h0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            av = ackVec();
            if (n < 3) begin
                checks++;
                if ({bus.o_memEn, bus.o_memWr, bus.o_memDataOe} !== 3'b100 || bus.o_memAddr !== 16'h1234 || av !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL read_access c%0d: got en/wr/oe %b addr %h ack %b want 100 1234 000",
                             n, {bus.o_memEn, bus.o_memWr, bus.o_memDataOe}, bus.o_memAddr, av);
                end
            end else begin
                checks++;
                if (av !== 3'b010 || bus.o_rdData !== 16'hBEEF || bus.o_memEn !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL read_done: got ack %b data %h en %b want 010 beef 0", av, bus.o_rdData, bus.o_memEn);
                end
                dropReq(1);
            end
        end
        refRdData = 16'hBEEF;
        refLastIsData = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [2:0] av;
        setReq(2, 1'b1, 1'b1, 16'h00FF, 16'hA5A5);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            av = ackVec();
            if (n < 3) begin
                checks++;
                if ({bus.o_memEn, bus.o_memWr, bus.o_memDataOe} !== 3'b111 || bus.o_memDataOut !== 16'hA5A5 ||
                    bus.o_memAddr !== 16'h00FF || av !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL write_access c%0d: got %b %h %h ack %b want 111 a5a5 00ff 000",
                             n, {bus.o_memEn, bus.o_memWr, bus.o_memDataOe}, bus.o_memDataOut, bus.o_memAddr, av);
                end
            end else begin
                checks++;
                if (av !== 3'b100 || bus.o_rdData !== refRdData || {bus.o_memEn, bus.o_memWr, bus.o_memDataOe} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL write_done: got ack %b rdData %h want 100 %h", av, bus.o_rdData, refRdData);
                end
                dropReq(2);
            end
        end
        refMem[16'h00FF] = 16'hA5A5;
        refLastIsData = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [2:0] av;
        logic [2:0] expVec;
        logic [1:0] expGrant;
        setReq(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        setReq(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        setReq(2, 1'b1, 1'b0, 16'h0030, 16'h0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            expVec = (n == 3) ? 3'b001 : (n == 7) ? 3'b010 : (n == 11) ? 3'b100 : 3'b000;
            av = ackVec();
            checks++;
            if (av !== expVec) begin
                errors++;
                $display("[TB] FAIL priority_ack c%0d: got %b want %b", n, av, expVec);
            end
            if (n == 1 || n == 5 || n == 9) begin
                expGrant = 2'((n + 3) / 4);
                checks++;
                if (bus.o_grant !== expGrant) begin
                    errors++;
                    $display("[TB] FAIL priority_grant c%0d: got %0d want %0d", n, bus.o_grant, expGrant);
                end
            end
            for (int r = 0; r < 3; r++) if (av[r]) dropReq(r);
        end
        refRdData = refMem[16'h0030];
        refLastIsData = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] expGrant;
        doReset();
        setReq(1, 1'b1, 1'b0, 16'h0001, 16'h0);
        setReq(2, 1'b1, 1'b0, 16'h0002, 16'h0);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n % 4 == 1) begin
                expGrant = ((n / 4) % 2 == 0) ? 2'd2 : 2'd3;
                checks++;
                if (bus.o_grant !== expGrant) begin
                    errors++;
                    $display("[TB] FAIL rr_grant #%0d: got %0d want %0d", n / 4, bus.o_grant, expGrant);
                end
            end
            if (n == 23) begin
                dropReq(1);
                dropReq(2);
            end
        end
        refRdData = refMem[16'h0002];
        refLastIsData = 1'b1;
    endtask

    task automatic test_late_change();
        logic [2:0] av;
        setReq(1, 1'b1, 1'b0, 16'h0100, 16'h0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) setReq(1, 1'b1, 1'b1, 16'h0200, 16'h7777);
            if (n == 2) begin
                checks++;
                if (bus.o_memAddr !== 16'h0100 || bus.o_memWr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL late_change: got addr %h wr %b want 0100 0", bus.o_memAddr, bus.o_memWr);
                end
            end
            if (n == 3) begin
                av = ackVec();
                checks++;
                if (av !== 3'b010 || bus.o_rdData !== refMem[16'h0100]) begin
                    errors++;
                    $display("[TB] FAIL late_change_done: got %b %h want 010 %h", av, bus.o_rdData, refMem[16'h0100]);
                end
                dropReq(1);
            end
        end
        refRdData = refMem[16'h0100];
        refLastIsData = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_req_drop_early();
        logic [2:0] av;
        setReq(2, 1'b1, 1'b1, 16'h0300, 16'h5555);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) dropReq(2);
            if (n == 3) begin
                av = ackVec();
                checks++;
                if (av !== 3'b100) begin
                    errors++;
                    $display("[TB] FAIL drop_early_ack: got %b want 100", av);
                end
            end
        end
        refMem[16'h0300] = 16'h5555;
        refLastIsData = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_param_sweep();
        int ack1N = 0;
        int ack15N = 0;
        int en15 = 0;
        doReset();
        bus1.i_jtagReq = 1'b1;  bus1.i_jtagWr = 1'b0;  bus1.i_jtagAddr = 16'h0005;
        bus15.i_jtagReq = 1'b1; bus15.i_jtagWr = 1'b0; bus15.i_jtagAddr = 16'h0005;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus15.o_memEn) en15++;
            if (bus1.o_jtagAck && ack1N == 0) begin
                ack1N = n;
                bus1.i_jtagReq = 1'b0;
            end
            if (bus15.o_jtagAck && ack15N == 0) begin
                ack15N = n;
                bus15.i_jtagReq = 1'b0;
            end
        end
        checks++;
        if (ack1N != 2 || bus1.o_rdData !== 16'hC0DE) begin
            errors++;
            $display("[TB] FAIL sweep_w1: got ack cycle %0d data %h want 2 c0de", ack1N, bus1.o_rdData);
        end
        checks++;
        if (ack15N != 16 || en15 != 15) begin
            errors++;
            $display("[TB] FAIL sweep_w15: got ack cycle %0d en cycles %0d want 16 15", ack15N, en15);
        end
        bus1.i_jtagReq = 1'b0;
        bus15.i_jtagReq = 1'b0;
    endtask

    // Each round raises a random subset of requesters; the model predicts service order and read data.
    task automatic test_random();
        int          order[$];
        logic [15:0] rAddr [3];
        logic [15:0] rData [3];
        logic        rWr   [3];
        int          mask;
        int          lastN;
        int          k;
        int          r;
        logic [2:0]  expVec;
        logic [2:0]  av;
        doReset();
        for (int round = 0; round < 40; round++) begin
            mask = $urandom_range(1, 7);
            order.delete();
            for (int i = 0; i < 3; i++) begin
                rWr[i]   = 1'($urandom_range(0, 1));
                rAddr[i] = 16'($urandom_range(0, 15));
                rData[i] = 16'($urandom);
            end
            if (mask[0]) order.push_back(0);
            if (mask[1] && mask[2]) begin
                if (refLastIsData) begin order.push_back(1); order.push_back(2); end
                else begin order.push_back(2); order.push_back(1); end
            end else if (mask[1]) begin
                order.push_back(1);
            end else if (mask[2]) begin
                order.push_back(2);
            end
            for (int i = 0; i < 3; i++) if (mask[i]) setReq(i, 1'b1, rWr[i], rAddr[i], rData[i]);
            lastN = (order.size() - 1) * (W + 2) + W + 1;
            for (int n = 1; n <= lastN + 1; n++) begin
                @(negedge clk);
                expVec = 3'b000;
                k = -1;
                for (int i = 0; i < order.size(); i++) begin
                    if (n == i * (W + 2) + W + 1) begin
                        expVec[order[i]] = 1'b1;
                        k = i;
                    end
                end
                av = ackVec();
                checks++;
                if (av !== expVec) begin
                    errors++;
                    $display("[TB] FAIL random_ack round %0d c%0d: got %b want %b", round, n, av, expVec);
                end
                if (k >= 0) begin
                    r = order[k];
                    if (rWr[r]) refMem[rAddr[r]] = rData[r];
                    else refRdData = refMem[rAddr[r]];
                    if (r == 1) refLastIsData = 1'b0;
                    else if (r == 2) refLastIsData = 1'b1;
                    checks++;
                    if (bus.o_rdData !== refRdData) begin
                        errors++;
                        $display("[TB] FAIL random_rdData round %0d: got %h want %h", round, bus.o_rdData, refRdData);
                    end
                end
                for (int i = 0; i < 3; i++) if (av[i]) dropReq(i);
            end
            for (int i = 0; i < 3; i++) dropReq(i);
        end
    endtask

    initial begin
        clearAll();
        for (int i = 0; i < 65536; i++) refMem[i] = 16'(i) ^ 16'h5A5A;
        test_reset();
        test_single_read();
        test_single_write();
        test_priority();
        test_round_robin();
        test_late_change();
        test_req_drop_early();
        test_param_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
